// File: rtl/tmds_decoder.sv
// tmds_decoder: single-channel TMDS symbol decoder with word-alignment tracking.
//   Stage 1 registers the raw symbol; stage 2 registers the decoded byte or
//   control pair. A SEARCH/SLIP/LOCKED tracker declares lock after a run of
//   control tokens, asks the deserializer to bit-slip when none is found, and
//   drops lock when control tokens stop arriving.
// Ports:
//   clk_in       pixel clock, rising edge
//   rst_n_in     synchronous active-low reset
//   tmds_in      raw 10-bit symbol, bit 0 first on the wire
//   data_out     decoded video byte (0 outside locked video)
//   control_out  decoded control pair, held across video
//   ve_out       1 = video byte valid, 0 = control period or unlocked
//   locked_out   word alignment achieved
//   bitslip_out  one-cycle request to shift the word boundary by one bit
module tmds_decoder #(
  parameter int unsigned CTRL_RUN       = 16,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned SLIP_WAIT      = 8,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned SLP_W  = $clog2(SLIP_WAIT + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [SLP_W-1:0]  SLP_LAST  = SLP_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SYM_W-1:0]   sym_q;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [SLP_W-1:0]   slip_q, slip_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               locked_q, locked_d;
  logic               bitslip_q, bitslip_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               ve_q, ve_d;

  logic               is_ctrl_c;
  logic [1:0]         ctrl_val_c;
  logic [BYTE_W-1:0]  vid_pre_c;
  logic [BYTE_W-1:0]  vid_c;

  // Control token recognition on the stage-1 symbol.
  always_comb begin
    is_ctrl_c  = 1'b1;
    ctrl_val_c = 2'b00;
    case (sym_q)
      CTRL_00: ctrl_val_c = 2'b00;
      CTRL_01: ctrl_val_c = 2'b01;
      CTRL_10: ctrl_val_c = 2'b10;
      CTRL_11: ctrl_val_c = 2'b11;
      default: is_ctrl_c  = 1'b0;
    endcase
  end

  // Video decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    vid_pre_c = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    vid_c     = '0;
    vid_c[0]  = vid_pre_c[0];
    for (int i = 1; i < BYTE_W; i++) begin
      vid_c[i] = sym_q[8] ? (vid_pre_c[i] ^ vid_pre_c[i-1])
                          : ~(vid_pre_c[i] ^ vid_pre_c[i-1]);
    end
  end

  // Alignment tracker next state.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    slip_d    = slip_q;
    loss_d    = loss_q;
    bitslip_d = 1'b0;
    // Run of consecutive control tokens, saturating so it never wraps.
    if (is_ctrl_c) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = '0;
    end

    case (state_q)
      ST_SEARCH: begin
        // Lock takes priority over a coincident timeout.
        if (run_q == RUN_MAX) begin
          state_d = ST_LOCKED;
          timer_d = '0;
          loss_d  = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d   = ST_SLIP;
          bitslip_d = 1'b1;
          timer_d   = '0;
          run_d     = '0;
          slip_d    = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SLIP: begin
        // Let the deserializer settle; ignore tokens seen meanwhile.
        run_d   = '0;
        timer_d = '0;
        if (slip_q == SLP_LAST) begin
          state_d = ST_SEARCH;
          slip_d  = '0;
        end else begin
          slip_d = slip_q + SLP_W'(1);
        end
      end
      ST_LOCKED: begin
        if (is_ctrl_c) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          timer_d = '0;
          slip_d  = '0;
          loss_d  = '0;
        end else begin
          loss_d = loss_q + LOSS_W'(1);
        end
      end
      default: begin
        state_d = ST_SEARCH;
        run_d   = '0;
        timer_d = '0;
        slip_d  = '0;
        loss_d  = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  // Stage-2 outputs; gating uses the lock value that appears alongside them.
  always_comb begin
    ctrl_d = is_ctrl_c ? ctrl_val_c : ctrl_q;
    ve_d   = locked_d & ~is_ctrl_c;
    data_d = ve_d ? vid_c : '0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_SEARCH;
      sym_q     <= '0;
      run_q     <= '0;
      timer_q   <= '0;
      slip_q    <= '0;
      loss_q    <= '0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= '0;
      ve_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_q     <= tmds_in;
      run_q     <= run_d;
      timer_q   <= timer_d;
      slip_q    <= slip_d;
      loss_q    <= loss_d;
      locked_q  <= locked_d;
      bitslip_q <= bitslip_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      ve_q      <= ve_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = ctrl_q;
  assign ve_out      = ve_q;
  assign locked_out  = locked_q;
  assign bitslip_out = bitslip_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: scoreboard bench for tmds_decoder. The driver pushes the
// expected response for each symbol; the monitor pops and compares each cycle.
module tb_tmds_decoder;

  localparam logic [9:0] TK00 = 10'b1101010100;
  localparam logic [9:0] TK01 = 10'b0010101011;
  localparam logic [9:0] TK10 = 10'b0101010100;
  localparam logic [9:0] TK11 = 10'b1010101011;
  localparam logic [9:0] V_A  = 10'b0111110000;  // -> 8'h10
  localparam logic [9:0] V_B  = 10'b1000000000;  // -> 8'hFF
  localparam logic [9:0] V_C  = 10'b0000000000;  // -> 8'hFE
  localparam logic [9:0] V_D  = 10'b1100000000;  // -> 8'h01
  localparam logic [9:0] V_E  = 10'b0110101010;  // -> 8'hFE

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic       bitslip_out;

  tmds_decoder dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .tmds_in     (tmds_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .locked_out  (locked_out),
    .bitslip_out (bitslip_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         due;
    bit         c_dv;
    bit         c_ctl;
    bit         c_loc;
    bit         c_slip;
    logic [7:0] data;
    logic       ve;
    logic [1:0] ctrl;
    logic       locked;
    logic       slip;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         slip_a = -1;
  int         slip_b = -1;
  int         rst_edge = 0;
  int         enc_cnt = 0;
  logic [1:0] last_ctrl = 2'b00;

  task automatic check(input string name, input int due,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, due, act, req);
    end
  endtask

  function automatic exp_t ex_sym(logic [7:0] data, logic ve, logic [1:0] ctrl, logic locked);
    exp_t e;
    e.due = 0; e.c_dv = 1'b1; e.c_ctl = 1'b1; e.c_loc = 1'b1; e.c_slip = 1'b1;
    e.data = data; e.ve = ve; e.ctrl = ctrl; e.locked = locked; e.slip = 1'b0;
    return e;
  endfunction

  function automatic exp_t ex_none();
    exp_t e;
    e.due = 0; e.c_dv = 1'b0; e.c_ctl = 1'b0; e.c_loc = 1'b0; e.c_slip = 1'b0;
    e.data = '0; e.ve = 1'b0; e.ctrl = '0; e.locked = 1'b0; e.slip = 1'b0;
    return e;
  endfunction

  function automatic logic [9:0] tok_of(logic [1:0] v);
    case (v)
      2'b00:   return TK00;
      2'b01:   return TK01;
      2'b10:   return TK10;
      default: return TK11;
    endcase
  endfunction

  // Reference DVI encoder with running disparity, zero latency.
  task automatic encode(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) enc_cnt += n1q - n0q;
      else       enc_cnt += n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  // Drive one symbol at the falling edge; queue its expectation lat edges later.
  task automatic drive(input logic [9:0] sym, input logic rst, input int lat, input exp_t e);
    @(negedge clk_in);
    tmds_in  = sym;
    rst_n_in = rst;
    e.due  = cyc + lat;
    e.slip = (e.due == slip_a) || (e.due == slip_b);
    if (e.c_dv || e.c_ctl || e.c_loc || e.c_slip) sbq.push_back(e);
  endtask

  task automatic send_tok(input logic [1:0] v, input logic lk);
    last_ctrl = v;
    enc_cnt   = 0;
    drive(tok_of(v), 1'b1, 2, ex_sym(8'h00, 1'b0, v, lk));
  endtask

  task automatic send_vid(input logic [9:0] sym, input logic [7:0] val, input logic lk);
    drive(sym, 1'b1, 2, ex_sym(lk ? val : 8'h00, lk, last_ctrl, lk));
  endtask

  // Filler cycle whose output the reset overwrites, then one reset cycle.
  task automatic do_reset();
    drive(V_C, 1'b1, 2, ex_none());
    drive(V_C, 1'b0, 1, ex_sym(8'h00, 1'b0, 2'b00, 1'b0));
    rst_edge  = cyc + 1;
    last_ctrl = 2'b00;
    enc_cnt   = 0;
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due < cyc) begin
          check("late_entry", e.due, cyc, e.due);
        end else begin
          if (e.c_dv) begin
            check("data_out", e.due, data_out, e.data);
            check("ve_out", e.due, ve_out, e.ve);
          end
          if (e.c_ctl)  check("control_out", e.due, control_out, e.ctrl);
          if (e.c_loc)  check("locked_out", e.due, locked_out, e.locked);
          if (e.c_slip) check("bitslip_out", e.due, bitslip_out, e.slip);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q;
    rst_n_in = 1'b0;
    tmds_in  = '0;

    // Reset state.
    do_reset();

    // 15-token run (mixed types) is one short of lock; video stays forced off.
    for (int i = 0; i < 14; i++) send_tok(2'b00, 1'b0);
    send_tok(2'b01, 1'b0);
    send_vid(V_A, 8'h10, 1'b0);

    // 16 tokens lock; the next video symbol decodes 2 cycles later.
    for (int i = 0; i < 16; i++) send_tok(2'b00, 1'b0);
    send_vid(V_A, 8'h10, 1'b1);

    // Locked: each control pair and the decode variants.
    send_tok(2'b11, 1'b1);
    send_vid(V_B, 8'hFF, 1'b1);
    send_vid(V_C, 8'hFE, 1'b1);
    send_vid(V_D, 8'h01, 1'b1);
    send_vid(V_E, 8'hFE, 1'b1);
    send_tok(2'b10, 1'b1);
    send_vid(V_A, 8'h10, 1'b1);
    send_tok(2'b01, 1'b1);

    // Encoder loopback over every byte with random control gaps.
    for (int v = 0; v < 256; v++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) send_tok(2'($urandom_range(0, 3)), 1'b1);
      encode(8'(v), q);
      send_vid(q, 8'(v), 1'b1);
    end

    // Loss of lock after LOSS_TIMEOUT video symbols with no control token.
    send_tok(2'b00, 1'b1);
    for (int i = 0; i < 4095; i++) send_vid(V_A, 8'h10, 1'b1);
    send_vid(V_A, 8'h10, 1'b0);
    send_vid(V_A, 8'h10, 1'b0);

    // Re-lock, then reset while locked: a fresh full run is needed.
    for (int i = 0; i < 16; i++) send_tok(2'b00, 1'b0);
    send_vid(V_D, 8'h01, 1'b1);
    send_tok(2'b01, 1'b1);
    send_tok(2'b01, 1'b1);
    do_reset();
    for (int i = 0; i < 15; i++) send_tok(2'b10, 1'b0);
    send_vid(V_A, 8'h10, 1'b0);
    for (int i = 0; i < 16; i++) send_tok(2'b10, 1'b0);
    send_vid(V_B, 8'hFF, 1'b1);

    // Search timeout: pulses at reset+2048 and reset+4104 (after 8 slip cycles).
    do_reset();
    slip_a = rst_edge + 2048;
    slip_b = rst_edge + 4104;
    for (int i = 0; i < 4106; i++) send_vid((i % 2 == 0) ? 10'h155 : 10'h0F0, 8'h00, 1'b0);

    // Reset lands inside the second slip wait; no further pulse may follow.
    do_reset();
    slip_a = -1;
    slip_b = -1;
    for (int i = 0; i < 40; i++) send_vid((i % 2 == 0) ? 10'h155 : 10'h0F0, 8'h00, 1'b0);

    repeat (4) @(negedge clk_in);
    check("scoreboard_drained", cyc, sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Parameters
REQ-001 The block SHALL have parameter CTRL_RUN, default 16, giving the consecutive control tokens needed to declare word lock.
REQ-002 The block SHALL have parameter SEARCH_TIMEOUT, default 2048, giving the cycles without lock in SEARCH before a bit-slip is requested.
REQ-003 The block SHALL have parameter SLIP_WAIT, default 8, giving the settle cycles after a bit-slip before searching resumes.
REQ-004 The block SHALL have parameter LOSS_TIMEOUT, default 4096, giving the cycles without any control token in LOCKED before lock is dropped.

Interface
REQ-005 The block SHALL have port clk_in, input, 1 bit: pixel clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port tmds_in, input, 10 bits: raw deserialized symbol, one per clock, bit 0 first on the wire.
REQ-008 The block SHALL have port data_out, output, 8 bits: decoded video byte.
REQ-009 The block SHALL have port control_out, output, 2 bits: decoded control pair; for the blue channel this is {vs,hs}.
REQ-010 The block SHALL have port ve_out, output, 1 bit: 1 = data_out valid video, 0 = control period.
REQ-011 The block SHALL have port locked_out, output, 1 bit: word alignment achieved.
REQ-012 The block SHALL have port bitslip_out, output, 1 bit: one-cycle request to the deserializer to shift word boundary by one bit.

Function
REQ-013 The block SHALL register tmds_in in stage 1 and register decoded outputs in stage 2, giving 2-cycle latency from tmds_in to data_out/control_out/ve_out.
REQ-014 The control token map SHALL be: 10'b1101010100 -> 2'b00, 10'b0010101011 -> 2'b01, 10'b0101010100 -> 2'b10, 10'b1010101011 -> 2'b11.
REQ-015 On a control token the decoder SHALL output ve_out=0, control_out per the map, data_out=0.
REQ-016 On any other symbol the decoder SHALL output ve_out=1 and hold control_out at its last value.
REQ-017 For a video symbol, d[7:0] SHALL be ~tmds[7:0] when tmds[9]=1, else tmds[7:0].
REQ-018 For a video symbol, data_out[0] SHALL be d[0].
REQ-019 For a video symbol, data_out[i] for i=1..7 SHALL be d[i]^d[i-1] when tmds[8]=1, else ~(d[i]^d[i-1]).
REQ-020 While locked_out=0, ve_out SHALL be forced to 0 and data_out to 0; control_out still decodes.
REQ-021 The FSM SHALL have states SEARCH, SLIP and LOCKED.
REQ-022 A run counter SHALL increment on each consecutive control token at stage 1, clear on any non-control symbol, and saturate at CTRL_RUN.
REQ-023 In SEARCH, when the run counter reaches CTRL_RUN the FSM SHALL go to LOCKED and assert locked_out on the next cycle.
REQ-024 In SEARCH, a timer SHALL count cycles; on reaching SEARCH_TIMEOUT-1 without lock the FSM SHALL pulse bitslip_out for exactly 1 cycle and enter SLIP.
REQ-025 SLIP SHALL wait SLIP_WAIT cycles with run counter and timer held at 0, then return to SEARCH.
REQ-026 In LOCKED, a loss timer SHALL clear on each control token; on reaching LOSS_TIMEOUT the FSM SHALL go to SEARCH, deassert locked_out, and clear all counters.
REQ-027 If lock and timeout coincide in SEARCH, lock SHALL win and no bit-slip is issued.
REQ-028 bitslip_out SHALL never be asserted in SLIP or LOCKED, and SHALL never be asserted on consecutive cycles.
REQ-029 All counters SHALL be wide enough for their parameter and SHALL NOT wrap.

Reset
REQ-030 With rst_n_in=0 at a rising edge, the block SHALL set data_out=0, control_out=0, ve_out=0, locked_out=0, bitslip_out=0, the pipeline to 0, all counters to 0, and the state to SEARCH, regardless of current state.
REQ-031 Reset asserted during SLIP SHALL cancel the wait, and no further bitslip_out pulse SHALL follow.

Verification
REQ-032 A bench SHALL cover: 16x 10'b1101010100 then 10'b0111110000 -> locked_out rises after the 16th token, and 2 cycles after the video symbol ve_out=1 and data_out=8'h10.
REQ-033 A bench SHALL cover: 2048 cycles of alternating 10'h155/10'h0F0 from reset -> a single 1-cycle bitslip_out on cycle 2048, then 8 quiet cycles, then a second pulse 2048 cycles later.
REQ-034 A bench SHALL cover: once locked, 4096 video symbols with no control token -> locked_out falls and ve_out is forced 0.
REQ-035 A bench SHALL cover: once locked, 10'b1010101011 -> control_out=2'b11, ve_out=0, with 2-cycle latency.
REQ-036 A bench SHALL cover: encoder loopback over all 256 data values with random control gaps -> decoded data equals the source, delayed by the encoder plus 2 cycles.
REQ-037 A bench SHALL cover: rst_n_in low for 1 cycle while locked -> all outputs 0 next cycle, and re-lock requires a fresh 16-token run.
